// File: rtl/lectura_rtc_pkg.sv
// rtl/lectura_rtc_pkg.sv - shared types and constants for the RTC read sequencer
//   estado_e          : bus sequencer states
//   T_*_DEF           : default setup / strobe / hold widths in clock cycles
//   RTC_*             : RTC register addresses (seconds .. year)
package lectura_rtc_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_A_SET,
      ST_A_WR,
      ST_A_HLD,
      ST_TURN,
      ST_D_SET,
      ST_D_RD,
      ST_D_HLD,
      ST_FIN
   } estado_e;

   localparam int T_SETUP_DEF = 2;
   localparam int T_PULSE_DEF = 4;
   localparam int T_HOLD_DEF  = 2;

   localparam logic [7:0] RTC_SEG   = 8'h00;
   localparam logic [7:0] RTC_MIN   = 8'h02;
   localparam logic [7:0] RTC_HORA  = 8'h04;
   localparam logic [7:0] RTC_FECHA = 8'h07;
   localparam logic [7:0] RTC_MES   = 8'h08;
   localparam logic [7:0] RTC_ANIO  = 8'h09;

endpackage

// File: rtl/bcd_a_bin.sv
// rtl/bcd_a_bin.sv - combinational two-digit BCD to 7-bit binary converter
//   bcd_i : packed BCD byte, tens in [7:4], units in [3:0]
//   bin_o : tens*10 + units, forced to 0 when either digit is invalid
//   err_o : 1 when either nibble is greater than 9
module bcd_a_bin (
   input  logic [7:0] bcd_i,
   output logic [6:0] bin_o,
   output logic       err_o
);

   logic [3:0] decenas;
   logic [3:0] unidades;

   assign decenas  = bcd_i[7:4];
   assign unidades = bcd_i[3:0];

   always_comb begin
      err_o = (decenas > 4'd9) || (unidades > 4'd9);
      bin_o = err_o ? 7'd0 : (7'(decenas) * 7'd10 + 7'(unidades));
   end

endmodule

// File: rtl/lectura_rtc.sv
// rtl/lectura_rtc.sv - read sequencer for the RTC multiplexed address/data bus
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   start_i, addr_i, mascara_i : read request, register address, capture mask
//   ad_in_i                  : AD bus pad input
//   ad_out_o, ad_oe_o        : AD bus drive value and enable
//   cs_n_o, ad_n_o, wr_n_o, rd_n_o : RTC bus controls (active-low strobes)
//   busy_o, done_o           : transaction in progress, one-cycle completion
//   dato_bcd_o, dato_bin_o, bcd_err_o : masked byte, its binary value, BCD error
module lectura_rtc
   import lectura_rtc_pkg::*;
#(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_PULSE = T_PULSE_DEF,
   parameter int T_HOLD  = T_HOLD_DEF
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] mascara_i,
   input  logic [7:0] ad_in_i,
   output logic [7:0] ad_out_o,
   output logic       ad_oe_o,
   output logic       cs_n_o,
   output logic       ad_n_o,
   output logic       wr_n_o,
   output logic       rd_n_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] dato_bcd_o,
   output logic [6:0] dato_bin_o,
   output logic       bcd_err_o
);

   localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                              : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
   localparam int CW = $clog2(T_MAX) + 1;

   // Counter reload values: a phase of N cycles counts N-1 down to 0.
   localparam logic [CW-1:0] CNT_SETUP = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] CNT_PULSE = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] CNT_HOLD  = CW'(T_HOLD - 1);

   estado_e         state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [7:0]      addr_q;
   logic [7:0]      mascara_q;
   logic            cs_n_q, ad_n_q, wr_n_q, rd_n_q, ad_oe_q, busy_q, done_q;
   logic [7:0]      dato_bcd_q;
   logic [6:0]      dato_bin_q;
   logic            bcd_err_q;

   logic            aceptar;
   logic            fin_fase;
   logic            captura;
   logic [7:0]      crudo;
   logic [6:0]      bin_nuevo;
   logic            err_nuevo;

   assign aceptar  = (state_q == ST_IDLE) && start_i;
   assign fin_fase = (cnt_q == '0);
   assign captura  = (state_q == ST_D_RD) && fin_fase;
   assign crudo    = ad_in_i & mascara_q;

   bcd_a_bin u_conv (
      .bcd_i (crudo),
      .bin_o (bin_nuevo),
      .err_o (err_nuevo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start_i) begin
               state_d = ST_A_SET;
               cnt_d   = CNT_SETUP;
            end
         end
         ST_A_SET: if (fin_fase) begin state_d = ST_A_WR;  cnt_d = CNT_PULSE; end
         ST_A_WR:  if (fin_fase) begin state_d = ST_A_HLD; cnt_d = CNT_HOLD;  end
         ST_A_HLD: if (fin_fase) begin state_d = ST_TURN;  cnt_d = '0;        end
         ST_TURN:  begin state_d = ST_D_SET; cnt_d = CNT_SETUP; end
         ST_D_SET: if (fin_fase) begin state_d = ST_D_RD;  cnt_d = CNT_PULSE; end
         ST_D_RD:  if (fin_fase) begin state_d = ST_D_HLD; cnt_d = CNT_HOLD;  end
         ST_D_HLD: if (fin_fase) begin state_d = ST_FIN;   cnt_d = '0;        end
         ST_FIN:   begin state_d = ST_IDLE; cnt_d = '0; end
         default:  begin state_d = ST_IDLE; cnt_d = '0; end
      endcase
   end

   // Outputs are decoded from the next state so each pin changes on the same
   // edge as the state it belongs to.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         mascara_q  <= '0;
         cs_n_q     <= 1'b1;
         ad_n_q     <= 1'b0;
         wr_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         ad_oe_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dato_bcd_q <= '0;
         dato_bin_q <= '0;
         bcd_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (aceptar) begin
            addr_q    <= addr_i;
            mascara_q <= mascara_i;
         end
         cs_n_q  <= (state_d == ST_IDLE) || (state_d == ST_FIN);
         ad_n_q  <= state_d inside {ST_TURN, ST_D_SET, ST_D_RD, ST_D_HLD, ST_FIN};
         wr_n_q  <= (state_d != ST_A_WR);
         rd_n_q  <= (state_d != ST_D_RD);
         ad_oe_q <= state_d inside {ST_A_SET, ST_A_WR, ST_A_HLD};
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_FIN);
         if (captura) begin
            dato_bcd_q <= crudo;
            dato_bin_q <= bin_nuevo;
            bcd_err_q  <= err_nuevo;
         end
      end
   end

   assign ad_out_o   = addr_q;
   assign ad_oe_o    = ad_oe_q;
   assign cs_n_o     = cs_n_q;
   assign ad_n_o     = ad_n_q;
   assign wr_n_o     = wr_n_q;
   assign rd_n_o     = rd_n_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign dato_bcd_o = dato_bcd_q;
   assign dato_bin_o = dato_bin_q;
   assign bcd_err_o  = bcd_err_q;

endmodule
